// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the 4-bit SAR ADC controller.
package sar_adc_pkg;

  localparam int unsigned DAC_BITS = 4;
  localparam logic [DAC_BITS-1:0] DIV_MIN = 4'd2;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    DONE
  } state_e;

endpackage

// File: rtl/cmp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
module cmp_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d};
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/sar_adc_4b_control.sv
// Successive-approximation controller: one DAC bit resolved per step of div+1 clocks.
module sar_adc_4b_control
  import sar_adc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_RESET   = 9
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                continuous,
  input  logic                load_divider,
  input  logic [DAC_BITS-1:0] data,
  input  logic                cmp_in,
  output logic [DAC_BITS-1:0] dac_code,
  output logic [DAC_BITS-1:0] result,
  output logic                valid,
  output logic                busy
);

  localparam logic [DAC_BITS-1:0] DivInit = DAC_BITS'(DIV_RESET);

  state_e              state_q, state_d;
  logic [DAC_BITS-1:0] dac_q, dac_d;
  logic [DAC_BITS-1:0] result_q, result_d;
  logic [DAC_BITS-1:0] div_q, div_d;
  logic [DAC_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          bit_idx_q, bit_idx_d;
  logic                valid_q, valid_d;
  logic                start_q;
  logic                cmp_s;
  logic                tick;

  cmp_sync #(
    .DEPTH(SYNC_STAGES)
  ) u_cmp_sync (
    .clk  (clk),
    .n_rst(n_rst),
    .d    (cmp_in),
    .q    (cmp_s)
  );

  assign tick = (cnt_q == div_q);

  always_comb begin
    state_d   = state_q;
    dac_d     = dac_q;
    result_d  = result_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Loaded divider takes effect for a coincident start as well.
        if (load_divider) begin
          div_d = (data < DIV_MIN) ? DIV_MIN : data;
        end
        if (start && !start_q) begin
          state_d   = TRIAL;
          dac_d     = 4'b1000;
          bit_idx_d = 2'd3;
          cnt_d     = '0;
        end
      end
      TRIAL: begin
        cnt_d = tick ? '0 : cnt_q + 4'd1;
        if (tick) begin
          if (!cmp_s) begin
            dac_d[bit_idx_q] = 1'b0;
          end
          if (bit_idx_q != 2'd0) begin
            dac_d[bit_idx_q - 2'd1] = 1'b1;
            bit_idx_d               = bit_idx_q - 2'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        result_d = dac_q;
        valid_d  = 1'b1;
        if (continuous) begin
          state_d   = TRIAL;
          dac_d     = 4'b1000;
          bit_idx_d = 2'd3;
          cnt_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      dac_q     <= '0;
      result_q  <= '0;
      div_q     <= DivInit;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dac_q     <= dac_d;
      result_q  <= result_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      valid_q   <= valid_d;
      start_q   <= start;
    end
  end

  assign dac_code = dac_q;
  assign result   = result_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sar_adc_4b_control.sv
// Randomized self-checking bench for sar_adc_4b_control with an ideal comparator model.
module tb_sar_adc_4b_control;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       load_divider = 1'b0;
  logic [3:0] data = 4'd0;
  logic       cmp_in = 1'b0;
  logic [3:0] dac_code;
  logic [3:0] result;
  logic       valid;
  logic       busy;

  logic [3:0] vin = 4'd0;
  logic [3:0] dac_seq[$];
  int checks = 0;
  int errors = 0;

  sar_adc_4b_control #(
    .SYNC_STAGES(2),
    .DIV_RESET  (9)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .continuous  (continuous),
    .load_divider(load_divider),
    .data        (data),
    .cmp_in      (cmp_in),
    .dac_code    (dac_code),
    .result      (result),
    .valid       (valid),
    .busy        (busy)
  );

  always #50 clk = ~clk;

  // Comparator with one clock of delay.
  always @(posedge clk) cmp_in <= (vin >= dac_code);

  // Expected edges from the sampling edge to the first edge after which valid is high.
  function automatic int lat(input int d);
    int dd;
    dd = (d < 2) ? 2 : d;
    return 4 * (dd + 1) + 1;
  endfunction

  task automatic load_div(input logic [3:0] d);
    @(negedge clk);
    load_divider = 1'b1;
    data = d;
    @(negedge clk);
    load_divider = 1'b0;
  endtask

  task automatic kick(input bit with_load, input logic [3:0] d);
    @(negedge clk);
    start = 1'b1;
    if (with_load) begin
      load_divider = 1'b1;
      data = d;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    load_divider = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    dac_seq.delete();
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (dac_seq.size() == 0 || dac_seq[$] !== dac_code) dac_seq.push_back(dac_code);
      if (valid === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #120;
    checks++;
    if ({dac_code, result, valid, busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got dac=%b res=%b v=%b b=%b want all 0",
               dac_code, result, valid, busy);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    logic [3:0] exp_seq[4];
    exp_seq = '{4'b1000, 4'b1100, 4'b1010, 4'b1011};
    vin = 4'd11;
    kick(1'b0, 4'd0);
    wait_valid(200, n);
    checks++;
    if (n !== lat(9)) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", n, lat(9));
    end
    checks++;
    if (result !== 4'b1011) begin
      errors++;
      $display("FAIL basic_result got %b want 1011", result);
    end
    checks++;
    if (dac_seq.size() != 4 || dac_seq[0] !== exp_seq[0] || dac_seq[1] !== exp_seq[1] ||
        dac_seq[2] !== exp_seq[2] || dac_seq[3] !== exp_seq[3]) begin
      errors++;
      $display("FAIL basic_dac_seq got %p want %p", dac_seq, exp_seq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_single_pulse got v=%b b=%b want 0 0", valid, busy);
    end
    checks++;
    if (dac_code !== 4'b1011) begin
      errors++;
      $display("FAIL basic_idle_hold got %b want 1011", dac_code);
    end
  endtask

  task automatic test_boundaries();
    int n;
    logic [3:0] vals[2];
    vals = '{4'd0, 4'd15};
    foreach (vals[k]) begin
      vin = vals[k];
      kick(1'b0, 4'd0);
      wait_valid(200, n);
      checks++;
      if (n !== lat(9) || result !== vals[k]) begin
        errors++;
        $display("FAIL boundary_%0d got lat=%0d res=%b want lat=%0d res=%b",
                 vals[k], n, result, lat(9), vals[k]);
      end
    end
  endtask

  task automatic test_divider();
    int n;
    vin = 4'd5;
    load_div(4'd1);
    kick(1'b0, 4'd0);
    wait_valid(200, n);
    checks++;
    if (n !== lat(2)) begin
      errors++;
      $display("FAIL div_clamp_latency got %0d want %0d", n, lat(2));
    end
    vin = 4'd6;
    kick(1'b1, 4'd5);
    wait_valid(200, n);
    checks++;
    if (n !== lat(5) || result !== 4'd6) begin
      errors++;
      $display("FAIL div_coincident got lat=%0d res=%b want lat=%0d res=0110", n, result, lat(5));
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int extra;
    vin = 4'd9;
    kick(1'b0, 4'd0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    load_divider = 1'b1;
    data = 4'd15;
    @(negedge clk);
    start = 1'b0;
    load_divider = 1'b0;
    wait_valid(200, n);
    n = n + 6;
    checks++;
    if (n !== lat(5) || result !== 4'd9) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d res=%b want lat=%0d res=1001", n, result, lat(5));
    end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_no_queue got %0d active cycles want 0", extra);
    end
    vin = 4'd2;
    kick(1'b0, 4'd0);
    wait_valid(200, n);
    checks++;
    if (n !== lat(5) || result !== 4'd2) begin
      errors++;
      $display("FAIL busy_div_kept got lat=%0d res=%b want lat=%0d res=0010", n, result, lat(5));
    end
  endtask

  task automatic test_continuous();
    int n;
    int extra;
    load_div(4'd9);
    continuous = 1'b1;
    vin = 4'd3;
    kick(1'b0, 4'd0);
    wait_valid(200, n);
    checks++;
    if (n !== lat(9) || result !== 4'd3) begin
      errors++;
      $display("FAIL cont_first got lat=%0d res=%b want lat=%0d res=0011", n, result, lat(9));
    end
    vin = 4'd12;
    wait_valid(200, n);
    checks++;
    if (n !== 41 || result !== 4'd12) begin
      errors++;
      $display("FAIL cont_second got period=%0d res=%b want period=41 res=1100", n, result);
    end
    continuous = 1'b0;
    wait_valid(200, n);
    checks++;
    if (n !== 41 || result !== 4'd12) begin
      errors++;
      $display("FAIL cont_last got period=%0d res=%b want period=41 res=1100", n, result);
    end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL cont_stop got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    vin = 4'd7;
    kick(1'b0, 4'd0);
    repeat (15) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({dac_code, result, valid, busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid got dac=%b res=%b v=%b b=%b want all 0",
               dac_code, result, valid, busy);
    end
    @(negedge clk);
    n_rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_idle got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_random();
    int n;
    int d;
    logic [3:0] v;
    for (int i = 0; i < 8; i++) begin
      // Step must cover the 1-clock comparator delay plus two synchronizer flops.
      d = $urandom_range(3, 15);
      v = 4'($urandom_range(0, 15));
      vin = v;
      load_div(4'(d));
      kick(1'b0, 4'd0);
      wait_valid(200, n);
      checks++;
      if (n !== lat(d) || result !== v) begin
        errors++;
        $display("FAIL random_%0d got lat=%0d res=%b want lat=%0d res=%b",
                 i, n, result, lat(d), v);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dac_code !== v || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_hold_%0d got dac=%b busy=%b want dac=%b busy=0", i, dac_code, busy, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_divider();
    test_busy_ignore();
    test_continuous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_4b_control.md
SAR_ADC_4B_CONTROL -- requirements
Module: sar_adc_4b_control

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: comparator synchronizer depth (2 or 3).
REQ-002 SHALL have parameter DIV_RESET, default 9: step divider value after reset (step = DIV_RESET+1 clk cycles).
REQ-003 SHALL have port clk  in  1  system clock, 10 MHz nominal; the block has one clock.
REQ-004 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  conversion request; acted on at its rising edge.
REQ-006 SHALL have port continuous  in  1  when high, back-to-back conversions with no restart needed.
REQ-007 SHALL have port load_divider  in  1  when high, load data into the step divider register.
REQ-008 SHALL have port data  in  4  divider reload value.
REQ-009 SHALL have port cmp_in  in  1  asynchronous comparator output; 1 means Vin >= Vdac.
REQ-010 SHALL have port dac_code  out  4  trial code driving the 4-bit R2R DAC b3..b0.
REQ-011 SHALL have port result  out  4  last completed conversion.
REQ-012 SHALL have port valid  out  1  one-cycle pulse when result updates.
REQ-013 SHALL have port busy  out  1  high while a conversion is in progress.

Function
REQ-014 SHALL pass cmp_in through SYNC_STAGES flops before any use; only the synchronized value is sampled.
REQ-015 SHALL keep a 4-bit div register; load_divider=1 in IDLE loads max(data, 2); in any other state it is ignored.
REQ-016 SHALL run the step counter only in TRIAL: cleared on TRIAL entry, tick when count==div, then wrap to 0.
REQ-017 SHALL implement the states IDLE, TRIAL and DONE.
REQ-018 IDLE: a start rising edge (start=1, previous sample 0) SHALL enter TRIAL next cycle with dac_code=4'b1000 and bit_idx=3.
REQ-019 TRIAL, on each tick: if synchronized cmp=0, SHALL clear dac_code[bit_idx].
REQ-020 TRIAL, on the same tick: if bit_idx>0, SHALL set dac_code[bit_idx-1] and decrement bit_idx; else SHALL enter DONE.
REQ-021 DONE, for one cycle: result<=dac_code and valid=1; SHALL go to TRIAL with dac_code=1000 if continuous=1, else to IDLE.
REQ-022 Latency: start edge sampled in cycle 0 -> valid high in cycle 4*(div+1)+2; continuous period = 4*(div+1)+1 cycles.
REQ-023 busy SHALL be 1 in TRIAL and DONE and 0 in IDLE.
REQ-024 Start edges while busy SHALL be ignored and SHALL NOT be queued.
REQ-025 dac_code SHALL hold the final code in IDLE.
REQ-026 A start edge coincident with load_divider in IDLE: the new div SHALL apply to that conversion.
REQ-027 Dropping continuous mid-conversion SHALL finish the current conversion, then return to IDLE.

Reset
REQ-028 n_rst=0 SHALL immediately force: state=IDLE; dac_code, result, bit_idx and the step counter = 0; valid=0; busy=0; div=DIV_RESET; synchronizer and start-edge flops = 0.
REQ-029 Reset mid-conversion SHALL abort with no valid pulse; after release the block SHALL wait for a new start edge.

Structure
REQ-030 Package sar_adc_pkg SHALL hold the state enum (IDLE/TRIAL/DONE), DIV_MIN=2 and DAC_BITS=4.
REQ-031 The synchronizer SHALL be a sub-module cmp_sync (parameterized depth, async active-low reset); everything else stays in sar_adc_4b_control.

Verification (comparator model: cmp_in = (vin_code >= dac_code), with 1 clk delay)
REQ-032 Reset, vin_code=11, start pulse -> dac_code sequence 1000,1100,1010,1011; result=1011; exactly one valid, at cycle 42.
REQ-033 vin_code=0 -> result 0000; vin_code=15 -> result 1111; boundary codes exact.
REQ-034 load_divider with data=1 in IDLE, then start -> div clamps to 2; valid at cycle 14; data=5 gives cycle 26.
REQ-035 continuous=1, vin_code 3 then 12 -> valid every 41 cycles; results 0011 then 1100; clearing continuous -> IDLE after the current result.
REQ-036 Start and load_divider pulsed while busy -> no restart and no div change; n_rst low mid-TRIAL -> all outputs 0, no valid, idle until the next start.
